// File: rtl/demux_8_router.sv
`default_nettype none
// ============================================================================
// Module      : demux_8_router
// Description : Byte-wide 1-to-2 demultiplexer with buffering. Each upstream
//               byte carries a select bit that steers it into one of two
//               independent output FIFOs. Each FIFO drains through its own
//               valid/ready handshake, so a stalled consumer never blocks
//               traffic bound for the other port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  data width in bits
//   DEPTH  entries per output FIFO (power of two, >= 2)
//   AW     pointer width, log2(DEPTH)
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        upstream handshake; in_ready = !full of the FIFO
//                            picked by in_sel
//   in_sel, in_data          destination port and payload
//   outN_valid/outN_ready    per-port drain handshake (N = 0, 1)
//   outN_data                FIFO N head entry, 0 while empty
//   fullN                    FIFO N holds DEPTH entries
// Optional feature (macro DEMUX_8_ROUTER_STATS_EN)
//   stats_clr                synchronous clear of the counters below
//   xfer0_cnt, xfer1_cnt     saturating counts of pushes into FIFO 0 / 1
//   stall_cnt                saturating count of cycles with in_valid && !in_ready
// ============================================================================
module demux_8_router #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             full0,
    output logic             full1
`ifdef DEMUX_8_ROUTER_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      xfer0_cnt,
    output logic [15:0]      xfer1_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    // Per-port vectors, index = port number.
    logic [1:0]       w_full;
    logic [1:0]       w_valid;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_out_ready;
    logic [WIDTH-1:0] w_head [2];
    logic             w_accept;

    assign w_out_ready = {out1_ready, out0_ready};

    // Acceptance only looks at the FIFO's current fullness; a pop happening
    // in the same cycle does not free a slot for the incoming byte.
    assign in_ready  = in_sel ? !w_full[1] : !w_full[0];
    assign w_accept  = in_valid && in_ready;
    assign w_push[0] = w_accept && !in_sel;
    assign w_push[1] = w_accept &&  in_sel;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [AW-1:0]    r_wr_ptr;
            logic [AW-1:0]    r_rd_ptr;
            logic [AW:0]      r_count;

            assign w_valid[g] = (r_count != '0);
            assign w_full[g]  = (r_count == C_DEPTH);
            assign w_pop[g]   = w_valid[g] && w_out_ready[g];
            // Head is forced to zero while empty so stale storage never leaks.
            assign w_head[g]  = w_valid[g] ? r_mem[r_rd_ptr] : '0;

            // Storage carries no reset: its contents are meaningless whenever
            // the count says the slot is unoccupied.
            always_ff @(posedge clk) begin
                if (w_push[g]) begin
                    r_mem[r_wr_ptr] <= in_data;
                end
            end

            // Pointers are exactly AW bits wide, so the increment wraps
            // modulo DEPTH on its own.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[g]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[g]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_push[g], w_pop[g]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = w_head[0];
    assign out1_data  = w_head[1];
    assign full0      = w_full[0];
    assign full1      = w_full[1];

`ifdef DEMUX_8_ROUTER_STATS_EN
    logic [15:0] r_xfer0_cnt;
    logic [15:0] r_xfer1_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = in_valid && !in_ready;

    // Clear wins over increment; all counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer0_cnt <= '0;
            r_xfer1_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (stats_clr) begin
            r_xfer0_cnt <= '0;
            r_xfer1_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push[0] && (r_xfer0_cnt != 16'hFFFF)) begin
                r_xfer0_cnt <= r_xfer0_cnt + 16'd1;
            end
            if (w_push[1] && (r_xfer1_cnt != 16'hFFFF)) begin
                r_xfer1_cnt <= r_xfer1_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign xfer0_cnt = r_xfer0_cnt;
    assign xfer1_cnt = r_xfer1_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
